// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/cacheline widths and the write-buffer state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    ACK
  } wb_state_t;

  localparam lc3b_word LINE_MASK = 16'hFFF0;

  // Cacheline-aligned base address of any byte address.
  function automatic lc3b_word lineBase(input lc3b_word addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/wb_entry.sv
// Single write-buffer entry: valid bit, line tag [15:4] and 128-bit line data.
module wb_entry
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [11:0]   tag_i,
  input  lc3b_cacheline data_i,
  output logic          valid_o,
  output logic [11:0]   tag_o,
  output lc3b_cacheline data_o
);

  logic          valid_q;
  logic [11:0]   tag_q;
  lc3b_cacheline data_q;

  // Load wins over clear; the FSM never asks for both in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cache_writebuffer.sv
// One-line victim write buffer between cache and physical memory.
// Optional WB_FORWARD_EN: reads hitting the buffered line are answered from the entry.
module cache_writebuffer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cache_read,
  input  logic          cache_write,
  input  lc3b_word      cache_address,
  input  lc3b_cacheline cache_wdata,
  output logic          cache_resp,
  output lc3b_cacheline cache_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_cacheline pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_cacheline pmem_rdata,
  output logic          buf_valid
);

  wb_state_t     state_q, state_d;
  logic          cache_resp_q, pmem_read_q, pmem_write_q;
  lc3b_word      pmem_address_q, pmem_address_d;
  lc3b_cacheline pmem_wdata_q, pmem_wdata_d;
  lc3b_cacheline cache_rdata_q, cache_rdata_d;

  logic          entry_load, entry_clear, start_drain;
  logic          entry_valid, hit;
  logic [11:0]   entry_tag;
  lc3b_cacheline entry_data;

  wb_entry u_entry (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (entry_load),
    .clear_i (entry_clear),
    .tag_i   (cache_address[15:4]),
    .data_i  (cache_wdata),
    .valid_o (entry_valid),
    .tag_o   (entry_tag),
    .data_o  (entry_data)
  );

  assign hit = entry_valid && (entry_tag == cache_address[15:4]);

  // Requests are only looked at in IDLE; a write wins over a simultaneous read,
  // and a missing read is serviced before the pending drain.
  always_comb begin
    state_d        = state_q;
    entry_load     = 1'b0;
    entry_clear    = 1'b0;
    start_drain    = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    cache_rdata_d  = cache_rdata_q;
    case (state_q)
      IDLE: begin
        if (cache_write) begin
          if (!entry_valid) begin
            entry_load = 1'b1;
            state_d    = ACK;
          end else begin
            start_drain = 1'b1;
          end
        end else if (cache_read && hit) begin
`ifdef WB_FORWARD_EN
          cache_rdata_d = entry_data;
          state_d       = ACK;
`else
          start_drain = 1'b1;
`endif
        end else if (cache_read) begin
          pmem_address_d = lineBase(cache_address);
          state_d        = READ;
        end else if (entry_valid) begin
          start_drain = 1'b1;
        end
      end
      READ: begin
        if (pmem_resp) begin
          cache_rdata_d = pmem_rdata;
          state_d       = ACK;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          entry_clear = 1'b1;
          state_d     = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_drain) begin
      pmem_address_d = {entry_tag, 4'h0};
      pmem_wdata_d   = entry_data;
      state_d        = DRAIN;
    end
  end

  // Strobes are registered decodes of the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cache_resp_q   <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      cache_rdata_q  <= '0;
    end else begin
      state_q        <= state_d;
      cache_resp_q   <= (state_d == ACK);
      pmem_read_q    <= (state_d == READ);
      pmem_write_q   <= (state_d == DRAIN);
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      cache_rdata_q  <= cache_rdata_d;
    end
  end

  assign cache_resp   = cache_resp_q;
  assign cache_rdata  = cache_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign buf_valid    = entry_valid;

endmodule

// File: tb/tb_cache_writebuffer.sv
// Scoreboard bench for cache_writebuffer: a "latest write wins" memory model
// predicts read data; a memory responder logs every pmem transaction.
module tb_cache_writebuffer;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cache_read, cache_write;
  lc3b_word      cache_address;
  lc3b_cacheline cache_wdata;
  logic          cache_resp;
  lc3b_cacheline cache_rdata;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  logic          pmem_resp;
  lc3b_cacheline pmem_rdata;
  logic          buf_valid;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  cache_writebuffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cache_read    (cache_read),
    .cache_write   (cache_write),
    .cache_address (cache_address),
    .cache_wdata   (cache_wdata),
    .cache_resp    (cache_resp),
    .cache_rdata   (cache_rdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .buf_valid     (buf_valid)
  );

  typedef struct {
    bit            isRead;
    lc3b_cacheline data;
  } expT;

  typedef struct {
    bit            isWrite;
    lc3b_word      addr;
    lc3b_cacheline data;
  } opT;

  expT           expQ[$];
  opT            opLog[$];
  lc3b_cacheline shadow[logic [11:0]];
  lc3b_cacheline mem[logic [11:0]];
  int            respCount = 0;
  bit            respEnable = 1'b1;
  int            respDelay = 0;
  bit            prevResp = 1'b0;

  function automatic lc3b_cacheline lineInit(input logic [11:0] line);
    return {8{4'hA, line}};
  endfunction

  function automatic lc3b_cacheline memLine(input logic [11:0] line);
    return mem.exists(line) ? mem[line] : lineInit(line);
  endfunction

  function automatic lc3b_cacheline modelRead(input logic [11:0] line);
    return shadow.exists(line) ? shadow[line] : lineInit(line);
  endfunction

  function automatic lc3b_cacheline randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every cache_resp pops one expected response.
  always @(negedge clk) begin
    if (rst_n && cache_resp) begin
      respCount++;
      checkOutput("resp_single_cycle", 128'(prevResp), 128'd0);
      checkOutput("resp_expected", 128'(expQ.size() != 0), 128'd1);
      if (expQ.size() != 0) begin
        expT e;
        e = expQ.pop_front();
        if (e.isRead) checkOutput("read_data", cache_rdata, e.data);
      end
    end
    prevResp = rst_n && cache_resp;
  end

  // Memory responder with random latency; respEnable lets a test withhold pmem_resp.
  always @(negedge clk) begin
    if (!rst_n) begin
      pmem_resp = 1'b0;
      respDelay = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if ((pmem_read || pmem_write) && respEnable) begin
      if (respDelay > 0) begin
        respDelay--;
      end else begin
        checkOutput("pmem_addr_aligned", 128'(pmem_address[3:0]), 128'd0);
        checkOutput("pmem_one_strobe", 128'(pmem_read && pmem_write), 128'd0);
        if (pmem_write) begin
          mem[pmem_address[15:4]] = pmem_wdata;
          opLog.push_back('{1'b1, pmem_address, pmem_wdata});
        end else begin
          pmem_rdata = memLine(pmem_address[15:4]);
          opLog.push_back('{1'b0, pmem_address, pmem_rdata});
        end
        pmem_resp = 1'b1;
        respDelay = $urandom_range(0, 3);
      end
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input lc3b_word addr,
                               input lc3b_cacheline data, output int lat);
    @(negedge clk);
    if (wr) begin
      shadow[addr[15:4]] = data;
      expQ.push_back('{1'b0, data});
    end else begin
      expQ.push_back('{1'b1, modelRead(addr[15:4])});
    end
    cache_read    = rd;
    cache_write   = wr;
    cache_address = addr;
    cache_wdata   = data;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cache_resp && lat < 200);
    if (!cache_resp) checkOutput("resp_timeout", 128'd0, 128'd1);
    @(negedge clk);
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic waitDrained();
    int n;
    n = 0;
    while ((buf_valid || pmem_write || pmem_read) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", 128'(buf_valid), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    automatic int lat;
    automatic int r0;
    automatic lc3b_cacheline d;
    automatic logic [11:0] lines[5] = '{12'h123, 12'h456, 12'h777, 12'h222, 12'h0AB};

    cache_read    = 1'b0;
    cache_write   = 1'b0;
    cache_address = '0;
    cache_wdata   = '0;
    pmem_resp     = 1'b0;
    pmem_rdata    = '0;
    rst_n         = 1'b0;
    #12;
    checkOutput("rst_cache_resp", 128'(cache_resp), 128'd0);
    checkOutput("rst_pmem_read", 128'(pmem_read), 128'd0);
    checkOutput("rst_pmem_write", 128'(pmem_write), 128'd0);
    checkOutput("rst_pmem_address", 128'(pmem_address), 128'd0);
    checkOutput("rst_pmem_wdata", pmem_wdata, 128'd0);
    checkOutput("rst_cache_rdata", cache_rdata, 128'd0);
    checkOutput("rst_buf_valid", 128'(buf_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write into empty buffer, then idle drain.
    opLog.delete();
    d = randLine();
    applyStimulus(1'b0, 1'b1, 16'h1230, d, lat);
    checkOutput("wr_empty_latency", 128'(lat), 128'd1);
    checkOutput("wr_empty_buf_valid", 128'(buf_valid), 128'd1);
    waitDrained();
    checkOutput("idle_drain_ops", 128'(opLog.size()), 128'd1);
    if (opLog.size() == 1) begin
      checkOutput("idle_drain_is_write", 128'(opLog[0].isWrite), 128'd1);
      checkOutput("idle_drain_addr", 128'(opLog[0].addr), 128'h1230);
      checkOutput("idle_drain_data", opLog[0].data, d);
    end

    // Read hitting the buffered line.
    opLog.delete();
    applyStimulus(1'b0, 1'b1, 16'h1230, randLine(), lat);
    applyStimulus(1'b1, 1'b0, 16'h1238, '0, lat);
`ifdef WB_FORWARD_EN
    checkOutput("fwd_latency", 128'(lat), 128'd1);
    checkOutput("fwd_no_pmem", 128'(opLog.size()), 128'd0);
`else
    checkOutput("hit_ops", 128'(opLog.size()), 128'd2);
    if (opLog.size() == 2) begin
      checkOutput("hit_first_write", 128'(opLog[0].isWrite), 128'd1);
      checkOutput("hit_first_addr", 128'(opLog[0].addr), 128'h1230);
      checkOutput("hit_then_read", 128'(opLog[1].isWrite), 128'd0);
      checkOutput("hit_read_addr", 128'(opLog[1].addr), 128'h1230);
    end
`endif
    waitDrained();

    // Miss read takes priority over the pending drain.
    opLog.delete();
    d = randLine();
    applyStimulus(1'b0, 1'b1, 16'h1230, d, lat);
    applyStimulus(1'b1, 1'b0, 16'h4560, '0, lat);
    waitDrained();
    checkOutput("prio_ops", 128'(opLog.size()), 128'd2);
    if (opLog.size() == 2) begin
      checkOutput("prio_read_first", 128'(opLog[0].isWrite), 128'd0);
      checkOutput("prio_read_addr", 128'(opLog[0].addr), 128'h4560);
      checkOutput("prio_drain_addr", 128'(opLog[1].addr), 128'h1230);
      checkOutput("prio_drain_data", opLog[1].data, d);
    end

    // Write into a full buffer: drain first, single response.
    opLog.delete();
    r0 = respCount;
    d = randLine();
    applyStimulus(1'b0, 1'b1, 16'h1230, d, lat);
    applyStimulus(1'b0, 1'b1, 16'h7770, randLine(), lat);
    checkOutput("wr_full_waits", 128'(lat > 1), 128'd1);
    checkOutput("wr_full_buf_valid", 128'(buf_valid), 128'd1);
    waitDrained();
    checkOutput("wr_full_resps", 128'(respCount - r0), 128'd2);
    checkOutput("wr_full_ops", 128'(opLog.size()), 128'd2);
    if (opLog.size() == 2) begin
      checkOutput("wr_full_old_addr", 128'(opLog[0].addr), 128'h1230);
      checkOutput("wr_full_old_data", opLog[0].data, d);
      checkOutput("wr_full_new_addr", 128'(opLog[1].addr), 128'h7770);
    end

    // Read and write together behave as a write.
    opLog.delete();
    applyStimulus(1'b1, 1'b1, 16'h2220, randLine(), lat);
    checkOutput("rw_latency", 128'(lat), 128'd1);
    checkOutput("rw_buf_valid", 128'(buf_valid), 128'd1);
    waitDrained();
    checkOutput("rw_ops", 128'(opLog.size()), 128'd1);
    if (opLog.size() == 1) begin
      checkOutput("rw_is_write", 128'(opLog[0].isWrite), 128'd1);
      checkOutput("rw_addr", 128'(opLog[0].addr), 128'h2220);
    end

    // Asynchronous reset in the middle of a drain.
    opLog.delete();
    applyStimulus(1'b0, 1'b1, 16'h3330, randLine(), lat);
    respEnable = 1'b0;
    r0 = 0;
    while (!pmem_write && r0 < 20) begin
      @(posedge clk);
      #1;
      r0++;
    end
    checkOutput("rst_drain_started", 128'(pmem_write), 128'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_pmem_write", 128'(pmem_write), 128'd0);
    checkOutput("rst_async_buf_valid", 128'(buf_valid), 128'd0);
    checkOutput("rst_async_pmem_address", 128'(pmem_address), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    respEnable = 1'b1;
    shadow[12'h333] = memLine(12'h333);
    checkOutput("rst_scoreboard_empty", 128'(expQ.size()), 128'd0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_no_strobe", 128'(pmem_write || pmem_read), 128'd0);
    end
    checkOutput("rst_discarded", 128'(opLog.size()), 128'd0);
    applyStimulus(1'b0, 1'b1, 16'h3330, randLine(), lat);
    checkOutput("rst_idle_empty", 128'(lat), 128'd1);
    waitDrained();

    // Randomized traffic over a few colliding lines.
    for (int i = 0; i < 120; i++) begin
      automatic int kind = $urandom_range(0, 3);
      automatic lc3b_word a = {lines[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(kind != 2, kind >= 2, a, randLine(), lat);
    end
    waitDrained();
    checkOutput("final_scoreboard_empty", 128'(expQ.size()), 128'd0);
    foreach (shadow[k]) checkOutput("final_mem", memLine(k), shadow[k]);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
